// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
// Arbiter states, grant sides and line/address sizes.
package arb_types;

  localparam int ARB_LINE_W = 256;
  localparam int ARB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_t;

  // Side that owns the transaction a busy state represents.
  function automatic arb_gnt_t served_side(
    input arb_state_t s
  );
    return (s == I_RD) ? GNT_I : GNT_D;
  endfunction

  // D-side busy state; a write wins if both flags are raised.
  function automatic arb_state_t d_kind(
    input logic wr
  );
    return wr ? D_WR : D_RD;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one pmem line port between the I-cache and D-cache.
// Ports: clk, rst (sync, active-low); i_pmem_* / d_pmem_* cache sides; pmem_* adaptor side.
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = ARB_LINE_W,
  parameter int ADDR_W = ARB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q;
  arb_state_t state_d;
  arb_gnt_t   last_q;
  arb_gnt_t   last_d;

  logic i_req;
  logic d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= GNT_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // On a tie the side that was not served last wins, so two
  // continuous requesters alternate strictly.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (i_req && d_req):
            state_d = (last_q == GNT_I) ?
                      d_kind(d_pmem_write) : I_RD;
          (i_req && !d_req):
            state_d = I_RD;
          (!i_req && d_req):
            state_d = d_kind(d_pmem_write);
          default:
            state_d = IDLE;
        endcase
      end
      default: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = served_side(state_q);
        end
      end
    endcase
  end

  // Outputs depend on state only, except the response, which is
  // passed through in the same cycle to the granted side.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_addr    = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    unique case (state_q)
      I_RD: begin
        pmem_read   = 1'b1;
        pmem_addr   = i_pmem_addr;
        i_pmem_resp = pmem_resp;
      end
      D_RD: begin
        pmem_read   = 1'b1;
        pmem_addr   = d_pmem_addr;
        d_pmem_resp = pmem_resp;
      end
      D_WR: begin
        pmem_write  = 1'b1;
        pmem_addr   = d_pmem_addr;
        pmem_wdata  = d_pmem_wdata;
        d_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  // Protocol checks on the cache and adaptor sides.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == IDLE) begin
        assert (!(d_pmem_read && d_pmem_write))
          else $warning("arb: d read+write together, taken as write");
        assert (!pmem_resp)
          else $warning("arb: pmem_resp while idle, ignored");
      end
      if (state_q == I_RD) begin
        assert (i_pmem_read)
          else $warning("arb: i request dropped before resp");
      end
      if (state_q == D_RD) begin
        assert (d_pmem_read)
          else $warning("arb: d read dropped before resp");
      end
      if (state_q == D_WR) begin
        assert (d_pmem_write)
          else $warning("arb: d write dropped before resp");
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter.
// Adaptor model checks issued transactions; monitor checks responses in order.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_addr    (pmem_addr),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int tests  = 0;
  int errors = 0;
  int lat    = 3;

  typedef struct {
    bit          d;
    logic [31:0] addr;
  } rsp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } tx_t;

  rsp_t rsp_q[$];
  tx_t  tx_q[$];

  logic [LW-1:0] a5_line;

  function automatic logic [LW-1:0] line_of(
    input logic [AW-1:0] a
  );
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(
    input string         name,
    input logic [LW-1:0] act,
    input logic [LW-1:0] exp
  );
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_resp(
    input bit    d,
    input string name
  );
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (d ? d_pmem_resp : i_pmem_resp) break;
      n++;
      if (n > 60) begin
        tests++;
        errors++;
        $display("FAIL %s: no resp within 60 cycles", name);
        break;
      end
    end
  endtask

  task automatic exp_tx(
    input bit            wr,
    input logic [AW-1:0] a,
    input logic [LW-1:0] wd
  );
    tx_t t;
    t.wr    = wr;
    t.addr  = a;
    t.wdata = wd;
    tx_q.push_back(t);
  endtask

  task automatic exp_rsp(
    input bit            d,
    input logic [AW-1:0] a
  );
    rsp_t r;
    r.d    = d;
    r.addr = a;
    rsp_q.push_back(r);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rd"},    pmem_read,   1'b0);
    check({name, "_wr"},    pmem_write,  1'b0);
    check({name, "_addr"},  pmem_addr,   '0);
    check({name, "_wdata"}, pmem_wdata,  '0);
    check({name, "_iresp"}, i_pmem_resp, 1'b0);
    check({name, "_dresp"}, d_pmem_resp, 1'b0);
  endtask

  // Adaptor model: checks each new transaction, answers after lat cycles.
  initial begin
    int  cnt;
    tx_t t;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      if (pmem_read || pmem_write) begin
        if (cnt == 0) begin
          if (tx_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL tx_unexpected: got addr %h want none",
                     pmem_addr);
          end else begin
            t = tx_q.pop_front();
            check("tx_write", pmem_write, t.wr);
            check("tx_read",  pmem_read,  !t.wr);
            check("tx_addr",  pmem_addr,  t.addr);
            if (t.wr) check("tx_wdata", pmem_wdata, t.wdata);
          end
        end
        cnt++;
        if (cnt >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = line_of(pmem_addr);
          cnt        = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Response monitor: pops the expected response in grant order.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        tests++;
        if (pmem_read && pmem_write) begin
          errors++;
          $display("FAIL rw_excl: got read=1 write=1 want one");
        end
        if (i_pmem_resp || d_pmem_resp) begin
          if (i_pmem_resp && d_pmem_resp) begin
            tests++;
            errors++;
            $display("FAIL resp_both: got both resp want one");
          end
          if (rsp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL rsp_unexpected: got i=%0b d=%0b want none",
                     i_pmem_resp, d_pmem_resp);
          end else begin
            r = rsp_q.pop_front();
            check("rsp_side", d_pmem_resp, r.d);
            check("rsp_rdata",
                  r.d ? d_pmem_rdata : i_pmem_rdata,
                  line_of(r.addr));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a5_line      = {32{8'hA5}};
    rst          = 1'b0;
    i_pmem_read  = 1'b0;
    i_pmem_addr  = '0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_addr  = '0;
    d_pmem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: lone I read, adaptor answers on its 5th busy cycle
    lat = 5;
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0060, '0);
    exp_rsp(1'b0, 32'h0000_0060);
    i_pmem_addr = 32'h0000_0060;
    i_pmem_read = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t1_rd_c%0d", c), pmem_read, c >= 1);
      check($sformatf("t1_iresp_c%0d", c), i_pmem_resp, c == 5);
      check($sformatf("t1_dresp_c%0d", c), d_pmem_resp, 1'b0);
    end
    @(posedge clk);
    #1 i_pmem_read = 1'b0;
    @(negedge clk);
    check("t1_idle", pmem_read, 1'b0);

    // 2: D write-back
    lat = 3;
    @(posedge clk);
    #1;
    exp_tx(1'b1, 32'h0000_1020, a5_line);
    exp_rsp(1'b1, 32'h0000_1020);
    d_pmem_addr  = 32'h0000_1020;
    d_pmem_wdata = a5_line;
    d_pmem_write = 1'b1;
    wait_resp(1'b1, "t2_resp");
    check("t2_write", pmem_write, 1'b1);
    check("t2_wdata", pmem_wdata, a5_line);
    check("t2_iresp", i_pmem_resp, 1'b0);
    @(posedge clk);
    #1 d_pmem_write = 1'b0;
    @(negedge clk);
    check_quiet("t2_idle");

    // 3: tie right after reset, I first, one idle cycle, then D
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_tx(1'b0, 32'h0000_0200, '0);
    exp_tx(1'b0, 32'h0000_0300, '0);
    exp_rsp(1'b0, 32'h0000_0200);
    exp_rsp(1'b1, 32'h0000_0300);
    i_pmem_addr = 32'h0000_0200;
    d_pmem_addr = 32'h0000_0300;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    wait_resp(1'b0, "t3_iresp");
    @(posedge clk);
    #1 i_pmem_read = 1'b0;
    @(negedge clk);
    check("t3_gap", pmem_read, 1'b0);
    @(negedge clk);
    check("t3_d_rd", pmem_read, 1'b1);
    check("t3_d_addr", pmem_addr, 32'h0000_0300);
    wait_resp(1'b1, "t3_dresp");
    @(posedge clk);
    #1 d_pmem_read = 1'b0;

    // 4: both held for four transactions, last grant was D
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0400, '0);
    exp_tx(1'b0, 32'h0000_0500, '0);
    exp_tx(1'b0, 32'h0000_0400, '0);
    exp_tx(1'b0, 32'h0000_0500, '0);
    exp_rsp(1'b0, 32'h0000_0400);
    exp_rsp(1'b1, 32'h0000_0500);
    exp_rsp(1'b0, 32'h0000_0400);
    exp_rsp(1'b1, 32'h0000_0500);
    i_pmem_addr = 32'h0000_0400;
    d_pmem_addr = 32'h0000_0500;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    fork
      begin
        repeat (2) wait_resp(1'b0, "t4_iresp");
        @(posedge clk);
        #1 i_pmem_read = 1'b0;
      end
      begin
        repeat (2) wait_resp(1'b1, "t4_dresp");
        @(posedge clk);
        #1 d_pmem_read = 1'b0;
      end
    join

    // 5: make last grant I, then reset inside a D read
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0600, '0);
    exp_rsp(1'b0, 32'h0000_0600);
    i_pmem_addr = 32'h0000_0600;
    i_pmem_read = 1'b1;
    wait_resp(1'b0, "t5_pre");
    @(posedge clk);
    #1 i_pmem_read = 1'b0;
    lat = 20;
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0700, '0);
    d_pmem_addr = 32'h0000_0700;
    d_pmem_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy", pmem_read, 1'b1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    d_pmem_read = 1'b0;
    @(negedge clk);
    check_quiet("t5_reset");
    lat = 3;
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0800, '0);
    exp_tx(1'b0, 32'h0000_0900, '0);
    exp_rsp(1'b0, 32'h0000_0800);
    exp_rsp(1'b1, 32'h0000_0900);
    i_pmem_addr = 32'h0000_0800;
    d_pmem_addr = 32'h0000_0900;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    fork
      begin
        wait_resp(1'b0, "t5_iresp");
        @(posedge clk);
        #1 i_pmem_read = 1'b0;
      end
      begin
        wait_resp(1'b1, "t5_dresp");
        @(posedge clk);
        #1 d_pmem_read = 1'b0;
      end
    join

    // 6: stray adaptor resp while idle
    @(posedge clk);
    #2 pmem_resp = 1'b1;
    @(negedge clk);
    check("t6_iresp", i_pmem_resp, 1'b0);
    check("t6_dresp", d_pmem_resp, 1'b0);
    check("t6_rd", pmem_read, 1'b0);
    @(negedge clk);
    check_quiet("t6_idle");
    @(posedge clk);
    #1;
    exp_tx(1'b0, 32'h0000_0A00, '0);
    exp_rsp(1'b0, 32'h0000_0A00);
    i_pmem_addr = 32'h0000_0A00;
    i_pmem_read = 1'b1;
    wait_resp(1'b0, "t6_after");
    @(posedge clk);
    #1 i_pmem_read = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("left_rsp", rsp_q.size(), 0);
    check("left_tx", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
